// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU: owns pc/ir/mar, drives memory and register-file strobes.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt with a sticky `illegal` flag on an undefined opcode.
module cpu_control_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        rf_ra,
  output logic [1:0]        rf_rb,
  output logic [1:0]        rf_wa,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              alu_sub,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ADDR, S_MEM, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [7:0]        ir_q, ir_d;
  logic [3:0]        opcode;

  assign opcode = ir_q[7:4];

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mar_d    = mar_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    mem_addr = pc_q;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_sub  = 1'b0;
    rf_ra    = ir_q[3:2];
    rf_rb    = ir_q[1:0];
    rf_wa    = ir_q[3:2];

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: if (run) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: if (run) begin
        case (opcode)
          OP_ADD, OP_SUB:    state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_HLT:            state_d = S_HALT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_ADDR: if (run) begin
        mar_d   = ADDR_W'(mem_rdata);
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_MEM;
      end
      S_MEM: begin
        mem_addr = mar_q;
        wb_sel   = (opcode == OP_LOAD);
        if (run) begin
          rf_we   = (opcode == OP_LOAD);
          mem_we  = (opcode == OP_STORE);
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_sub = (opcode == OP_SUB);
        if (run) begin
          rf_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    // Strobes are Moore outputs; mask them so a reset cycle never commits a write.
    if (reset) begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus random programs scored by an ISA-level model.
module tb_cpu_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] mem_rdata, mem_addr, pc;
  logic       mem_we, rf_we, wb_sel, alu_sub, halted, illegal;
  logic [1:0] rf_ra, rf_rb, rf_wa;

  logic [7:0] mem [256];
  logic [7:0] rf [4];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rf [4];
  int n_cmp = 0, n_fail = 0, stb_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  cpu_control_unit #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_sub(alu_sub), .pc(pc), .halted(halted), .illegal(illegal)
  );

  // One clock: sample at negedge, model memory/register-file writes just after the edge.
  task automatic tick();
    logic w_rf, w_mem;
    logic [1:0] wa;
    logic [7:0] wd, ma, md;
    @(negedge clk);
    if (mon_en) begin
      n_cmp++;
      if (rf_we === 1'b1 && mem_we === 1'b1) begin
        n_fail++; $display("FAIL strobe_overlap: rf_we=%b mem_we=%b required not both 1", rf_we, mem_we);
      end
      if (!run || halted === 1'b1 || reset) begin
        n_cmp++;
        if (rf_we !== 1'b0 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL idle_strobe: rf_we=%b mem_we=%b required 0/0 (run=%b halted=%b reset=%b)", rf_we, mem_we, run, halted, reset);
        end
      end
    end
    w_rf  = (rf_we === 1'b1);
    w_mem = (mem_we === 1'b1);
    wa    = rf_wa;
    wd    = wb_sel ? mem_rdata : (alu_sub ? rf[rf_ra] - rf[rf_rb] : rf[rf_ra] + rf[rf_rb]);
    ma    = mem_addr;
    md    = rf[rf_ra];
    @(posedge clk);
    #1;
    if (w_rf) begin rf[wa] = wd; stb_cnt++; end
    if (w_mem) begin mem[ma] = md; stb_cnt++; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 4; r++) rf[r] = 8'($urandom);
  endtask

  // Instruction-level interpreter: returns cycles from reset release to halted, strobe count, final pc.
  task automatic ref_run(output int cyc, output int nstb, output logic [7:0] fpc, output logic fill);
    logic [7:0] p, op, a;
    bit done;
    cyc = 1; nstb = 0; p = 8'h00; fill = 1'b0; done = 1'b0;
    for (int g = 0; g < 300 && !done; g++) begin
      op = ref_mem[p]; p = p + 8'd1;
      case (op[7:4])
        4'h1: begin ref_rf[op[3:2]] = ref_rf[op[3:2]] + ref_rf[op[1:0]]; cyc += 3; nstb++; end
        4'h2: begin ref_rf[op[3:2]] = ref_rf[op[3:2]] - ref_rf[op[1:0]]; cyc += 3; nstb++; end
        4'h9: begin a = ref_mem[p]; p = p + 8'd1; ref_rf[op[3:2]] = ref_mem[a]; cyc += 4; nstb++; end
        4'hD: begin a = ref_mem[p]; p = p + 8'd1; ref_mem[a] = ref_rf[op[3:2]]; cyc += 4; nstb++; end
        4'hF: begin cyc += 2; done = 1'b1; end
        default: begin
          cyc += 2;
`ifdef CTRL_ILLEGAL_TRAP_EN
          done = 1'b1; fill = 1'b1;
`endif
        end
      endcase
    end
    fpc = p;
  endtask

  task automatic test_reset();
    fill_random(); run = 1'b1; mon_en = 1'b1;
    do_reset();
    n_cmp++; if (pc !== 8'h00 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: pc=%h mem_addr=%h required 00/00", pc, mem_addr); end
    n_cmp++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_flags: halted=%b illegal=%b required 0/0", halted, illegal); end
    n_cmp++; if (rf_we !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: rf_we=%b mem_we=%b required 0/0", rf_we, mem_we); end
    mem[0] = 8'h11;
    do_reset(); ticks(3);
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL abort_pre: rf_we=%b required 1", rf_we); end
    reset = 1'b1; #1;
    n_cmp++; if (rf_we !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_strobe: rf_we=%b mem_we=%b required 0/0", rf_we, mem_we); end
    tick(); reset = 1'b0;
    n_cmp++; if (pc !== 8'h00 || halted !== 1'b0) begin n_fail++; $display("FAIL abort_state: pc=%h halted=%b required 00/0", pc, halted); end
  endtask

  task automatic test_add();
    logic [7:0] exp;
    fill_random(); mem[0] = 8'h11; exp = rf[0] + rf[1]; run = 1'b1;
    do_reset(); tick();
    n_cmp++; if (mem_addr !== 8'h00 || rf_we !== 1'b0) begin n_fail++; $display("FAIL add_fetch: mem_addr=%h rf_we=%b required 00/0", mem_addr, rf_we); end
    ticks(2);
    n_cmp++; if ({rf_we, rf_wa, rf_rb, alu_sub, wb_sel} !== {1'b1, 2'd0, 2'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_exec: we=%b wa=%0d rb=%0d sub=%b wb=%b required 1/0/1/0/0", rf_we, rf_wa, rf_rb, alu_sub, wb_sel); end
    n_cmp++; if (pc !== 8'h01) begin n_fail++; $display("FAIL add_pc: pc=%h required 01", pc); end
    tick();
    n_cmp++; if (rf[0] !== exp || rf_we !== 1'b0) begin n_fail++; $display("FAIL add_result: r0=%h rf_we=%b required %h/0", rf[0], rf_we, exp); end
  endtask

  task automatic test_load();
    logic [7:0] d;
    fill_random(); mem[0] = 8'h90; mem[1] = 8'h20; d = mem[8'h20]; run = 1'b1;
    do_reset(); ticks(3);
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL load_early: rf_we=%b required 0", rf_we); end
    tick();
    n_cmp++; if ({mem_addr, rf_we, wb_sel, rf_wa} !== {8'h20, 1'b1, 1'b1, 2'd0}) begin
      n_fail++; $display("FAIL load_mem: addr=%h we=%b wb=%b wa=%0d required 20/1/1/0", mem_addr, rf_we, wb_sel, rf_wa); end
    n_cmp++; if (pc !== 8'h02) begin n_fail++; $display("FAIL load_pc: pc=%h required 02", pc); end
    tick();
    n_cmp++; if (rf[0] !== d) begin n_fail++; $display("FAIL load_data: r0=%h required %h", rf[0], d); end
  endtask

  task automatic test_load_wrap();
    fill_random(); mem[0] = 8'h21;
    for (int i = 1; i < 255; i++) mem[i] = 8'h10;
    mem[255] = 8'h94; run = 1'b1;
    do_reset(); ticks(1 + 255 * 3);
    n_cmp++; if (pc !== 8'hFF || mem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_fetch: pc=%h mem_addr=%h required FF/FF", pc, mem_addr); end
    ticks(3);
    n_cmp++; if ({mem_addr, rf_we, wb_sel, rf_wa} !== {8'h21, 1'b1, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL wrap_mem: addr=%h we=%b wb=%b wa=%0d required 21/1/1/1", mem_addr, rf_we, wb_sel, rf_wa); end
    n_cmp++; if (pc !== 8'h01) begin n_fail++; $display("FAIL wrap_pc: pc=%h required 01", pc); end
    tick();
    n_cmp++; if (rf[1] !== 8'h10) begin n_fail++; $display("FAIL wrap_data: r1=%h required 10", rf[1]); end
  endtask

  task automatic test_store();
    logic [7:0] v;
    fill_random(); mem[0] = 8'hD4; mem[1] = 8'h41; v = rf[1]; run = 1'b1;
    do_reset(); ticks(3);
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_early: mem_we=%b required 0", mem_we); end
    tick();
    n_cmp++; if ({mem_addr, mem_we, rf_ra, rf_we} !== {8'h41, 1'b1, 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL store_mem: addr=%h mem_we=%b ra=%0d rf_we=%b required 41/1/1/0", mem_addr, mem_we, rf_ra, rf_we); end
    tick();
    n_cmp++; if (mem_we !== 1'b0 || mem[8'h41] !== v) begin n_fail++; $display("FAIL store_after: mem_we=%b mem41=%h required 0/%h", mem_we, mem[8'h41], v); end
  endtask

  task automatic test_stall_sub();
    logic [7:0] exp;
    fill_random(); mem[0] = 8'h22; exp = rf[0] - rf[2]; run = 1'b1;
    do_reset(); ticks(3);
    run = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rf_we !== 1'b0 || pc !== 8'h01) begin n_fail++; $display("FAIL stall_hold: rf_we=%b pc=%h required 0/01", rf_we, pc); end
      tick();
    end
    run = 1'b1; #1;
    n_cmp++; if (rf_we !== 1'b1 || alu_sub !== 1'b1) begin n_fail++; $display("FAIL stall_resume: rf_we=%b alu_sub=%b required 1/1", rf_we, alu_sub); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || rf[0] !== exp) begin n_fail++; $display("FAIL stall_once: rf_we=%b r0=%h required 0/%h", rf_we, rf[0], exp); end
  endtask

  task automatic test_illegal();
    fill_random(); mem[0] = 8'h50; mem[1] = 8'h50; run = 1'b1;
    do_reset(); ticks(2);
    n_cmp++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL ill_decode: halted=%b illegal=%b required 0/0", halted, illegal); end
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_cmp++; if ({illegal, halted, pc} !== {1'b1, 1'b1, 8'h01}) begin n_fail++; $display("FAIL ill_trap: illegal=%b halted=%b pc=%h required 1/1/01", illegal, halted, pc); end
    ticks(4);
    n_cmp++; if ({illegal, halted, pc} !== {1'b1, 1'b1, 8'h01}) begin n_fail++; $display("FAIL ill_sticky: illegal=%b halted=%b pc=%h required 1/1/01", illegal, halted, pc); end
`else
    n_cmp++; if ({illegal, halted, pc, mem_addr} !== {1'b0, 1'b0, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL ill_nop: illegal=%b halted=%b pc=%h addr=%h required 0/0/01/01", illegal, halted, pc, mem_addr); end
`endif
  endtask

  task automatic test_program(input int nbytes, input bit allow_ill, input bit stall);
    int p, k, cyc, nstb, n, diffs, stb0;
    logic [7:0] fpc, pc0;
    logic fill;
    logic [3:0] ill_ops [11] = '{4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE};
    fill_random();
    p = 0;
    while (p < nbytes) begin
      k = $urandom_range(0, allow_ill ? 4 : 3);
      if (p == nbytes - 1 && (k == 2 || k == 3)) k = 0;
      case (k)
        0: begin mem[p] = {4'h1, 4'($urandom)}; p += 1; end
        1: begin mem[p] = {4'h2, 4'($urandom)}; p += 1; end
        2: begin mem[p] = {4'h9, 4'($urandom)}; mem[p+1] = 8'($urandom); p += 2; end
        3: begin mem[p] = {4'hD, 4'($urandom)}; mem[p+1] = 8'($urandom_range(8'hC0, 8'hFF)); p += 2; end
        default: begin mem[p] = {ill_ops[$urandom_range(0, 10)], 4'($urandom)}; p += 1; end
      endcase
    end
    mem[nbytes] = 8'hF0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int r = 0; r < 4; r++) ref_rf[r] = rf[r];
    ref_run(cyc, nstb, fpc, fill);
    run = 1'b1;
    do_reset();
    stb_cnt = 0; n = 0;
    while (halted !== 1'b1 && n < 3000) begin
      if (stall) run = ($urandom_range(0, 3) != 0);
      tick(); n++;
    end
    run = 1'b1;
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL prog_timeout: halted=%b after %0d cycles required 1", halted, n); end
    if (!stall) begin
      n_cmp++; if (n != cyc) begin n_fail++; $display("FAIL prog_cycles: %0d cycles required %0d", n, cyc); end
    end
    n_cmp++; if (pc !== fpc || illegal !== fill) begin n_fail++; $display("FAIL prog_end: pc=%h illegal=%b required %h/%b", pc, illegal, fpc, fill); end
    if (nbytes == 27) begin
      n_cmp++; if (pc !== 8'h1C) begin n_fail++; $display("FAIL prog28_pc: pc=%h required 1C", pc); end
    end
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (rf[r] !== ref_rf[r]) begin n_fail++; $display("FAIL prog_reg%0d: got %h required %h", r, rf[r], ref_rf[r]); end
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++; if (diffs != 0) begin n_fail++; $display("FAIL prog_mem: %0d differing bytes required 0", diffs); end
    n_cmp++; if (stb_cnt != nstb) begin n_fail++; $display("FAIL prog_strobes: %0d strobes required %0d", stb_cnt, nstb); end
    stb0 = stb_cnt; pc0 = pc;
    for (int i = 0; i < 100; i++) begin run = 1'($urandom); tick(); end
    n_cmp++; if (stb_cnt != stb0 || pc !== pc0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_absorb: strobes=%0d pc=%h halted=%b required %0d/%h/1", stb_cnt, pc, halted, stb0, pc0); end
    run = 1'b0;
    do_reset();
    n_cmp++; if ({pc, halted, illegal} !== {8'h00, 1'b0, 1'b0}) begin n_fail++; $display("FAIL post_reset: pc=%h halted=%b illegal=%b required 00/0/0", pc, halted, illegal); end
    ticks(2);
    n_cmp++; if (pc !== 8'h00 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL idle_hold: pc=%h mem_addr=%h required 00/00", pc, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_load_wrap();
    test_store();
    test_stall_sub();
    test_illegal();
    test_program(27, 1'b0, 1'b0);
    test_program(60, 1'b1, 1'b0);
    test_program(60, 1'b1, 1'b1);
    test_program(40, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It owns the program counter, instruction register and operand-address register. It drives the single shared byte-wide memory port, the 4-entry register file strobes and the ALU add/sub select. It sits between the instruction/data memory and the register-file/ALU datapath, and is the only block that issues memory or register writes.

## Interface
- `ADDR_W`, 8, memory address width; PC wraps modulo 2^ADDR_W
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `run` in 1: execution enable; 0 = stall
- `mem_rdata` in 8: memory read data, combinational from `mem_addr`
- `mem_addr` out ADDR_W: memory address
- `mem_we` out 1: memory write strobe; store data is register-file port A, wired at top level
- `rf_ra` out 2: register-file read port A select
- `rf_rb` out 2: register-file read port B select
- `rf_wa` out 2: register write address
- `rf_we` out 1: register write strobe
- `wb_sel` out 1: write-back source; 0 = ALU result, 1 = `mem_rdata`
- `alu_sub` out 1: ALU op; 0 = A+B, 1 = A−B (mod 256)
- `pc` out ADDR_W: program counter
- `halted` out 1: HALT state reached
- `illegal` out 1: illegal-opcode trap (sticky)

## Operation
- Encoding:
  - `ir[7:4]` opcode; `ir[3:2]` rd (store source for STORE); `ir[1:0]` rs.
  - 0x1 ADD: rd ← rd + rs.
  - 0x2 SUB: rd ← rd − rs.
  - 0x9 LOAD: rd ← mem[op2].
  - 0xD STORE: mem[op2] ← rd.
  - 0xF HLT.
  - LOAD/STORE are two bytes; the second byte (op2) is the address. All other opcodes are illegal.
- States: IDLE, FETCH, DECODE, ADDR, MEM, EXEC, HALT. Outputs are a Moore decode of registered state plus `ir`/`mar`/`pc`.
- IDLE:
  - `mem_addr`=`pc`, no strobes.
  - → FETCH when `run`.
- FETCH:
  - `mem_addr`=`pc`; latch `ir`←`mem_rdata`; `pc`←`pc`+1.
  - → DECODE.
- DECODE:
  - ADD/SUB → EXEC.
  - LOAD/STORE → ADDR.
  - HLT → HALT.
  - Illegal → see Configuration.
- ADDR:
  - `mem_addr`=`pc`; latch `mar`←`mem_rdata`; `pc`←`pc`+1.
  - → MEM.
- MEM:
  - `mem_addr`=`mar`.
  - LOAD: `rf_we`=1, `wb_sel`=1, `rf_wa`=rd.
  - STORE: `mem_we`=1, `rf_ra`=rd.
  - → FETCH.
- EXEC:
  - `rf_ra`=`rf_wa`=rd, `rf_rb`=rs, `wb_sel`=0, `alu_sub`=(opcode==0x2), `rf_we`=1.
  - → FETCH.
- HALT:
  - Absorbing; `halted`=1; no strobes; `pc` frozen.
  - Exit only by `reset`.
- `rf_ra`/`rf_rb` = `ir[3:2]`/`ir[1:0]` in every state; harmless when no strobe.

## Timing
- Reset values:
  - state IDLE; `pc`=0, `ir`=0, `mar`=0.
  - `halted`=0, `illegal`=0, `mem_we`=0, `rf_we`=0, `mem_addr`=0.
- Latency from FETCH entry:
  - ADD/SUB 3 cycles; write on cycle 3.
  - LOAD/STORE 4 cycles; strobe on cycle 4.
  - HLT: `halted` rises 2 cycles after FETCH.
- Strobes (`rf_we`, `mem_we`) last exactly one cycle per instruction. Never both high together.
- `run`=0 in any state except HALT:
  - state, `pc`, `ir`, `mar` hold.
  - `rf_we`=`mem_we`=0.
  - `mem_addr` keeps its state-defined value.
  - When `run` returns, the held state executes once.
- `pc` wrap: 0xFF+1 = 0x00. A two-byte instruction at 0xFF takes its operand from 0x00.
- `reset` has priority over `run` and any state. Reset mid-instruction aborts it with no strobe in the reset cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - Illegal opcode in DECODE → HALT, with `illegal`=1 and `halted`=1 from the next cycle.
  - `pc` stays at the illegal address +1.
- Not defined:
  - Illegal opcode is a 2-cycle NOP: DECODE → FETCH, no strobes.
  - `illegal` is tied 0.

## Test plan
- Reset, `run`=1, mem[0]=0x11 -> FETCH on cycle 1; EXEC on cycle 3 with `rf_we`=1, `rf_wa`=0, `rf_rb`=1, `alu_sub`=0, `wb_sel`=0; `pc`=1.
- mem[0..1]=0x90,0x20 -> MEM cycle shows `mem_addr`=0x20, `rf_we`=1, `wb_sel`=1, `rf_wa`=0; `pc`=2. Repeat with `pc` preset via program at 0xFF (0x94) and mem[0]=0x21 -> `mar`=0x21, `pc`=0x01.
- mem[0..1]=0xD4,0x41 -> MEM cycle `mem_addr`=0x41, `mem_we`=1 for exactly 1 cycle, `rf_ra`=1, `rf_we`=0.
- Run the 28-byte mixed program ending in 0xF0 at 0x1B -> `halted`=1, `pc`=0x1C, zero strobes over 100 further cycles. Then `reset` -> `pc`=0, `halted`=0, IDLE.
- 0x22 (SUB) with `run` low for 3 cycles while in EXEC -> `rf_we`=0 during stall, one `rf_we` pulse with `alu_sub`=1 after `run` returns.
- mem[0]=0x50 -> with `CTRL_ILLEGAL_TRAP_EN`: `illegal`=1, `halted`=1, `pc`=1. Without it: back to FETCH, `pc`=1, no strobes.
